// File: rtl/avr_dbg_pkg.sv
// Shared definitions for the AVR debug register-port engine: op codes,
// response bytes and FSM states.
package avr_dbg_pkg;

  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_DUMP  = 3'b011;

  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  localparam logic [4:0] LAST_REG = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_DATA,
    ST_ACCESS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/avr_dbg_regport.sv
// Debug engine for the 32x8 AVR register file: halts the CPU, reads/writes/dumps
// registers. Define AVR_DBG_DUMP_EN to compile in the DUMP op and its counter.
module avr_dbg_regport
  import avr_dbg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       halt_req,
  input  logic       halt_ack,
  output logic [4:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic       reg_we,
  output logic [7:0] reg_wdata
);

`ifdef AVR_DBG_DUMP_EN
  localparam logic DUMP_EN = 1'b1;
`else
  localparam logic DUMP_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [4:0] addr_q;
  logic       err_q;
  logic [7:0] rsp_q;
  logic [7:0] wdata_q;
  logic [2:0] cmd_op;
  logic       cmd_err;
  logic       is_dump;
  logic       dump_more;

  assign cmd_op  = cmd_data[7:5];
  assign cmd_err = !((cmd_op == OP_READ) || (cmd_op == OP_WRITE) ||
                     (DUMP_EN && (cmd_op == OP_DUMP)));

`ifdef AVR_DBG_DUMP_EN
  logic [4:0] cnt_q;

  assign is_dump   = (op_q == OP_DUMP) && !err_q;
  assign dump_more = is_dump && (cnt_q != LAST_REG);
  assign reg_addr  = is_dump ? cnt_q : addr_q;

  // Counter restarts on every DUMP accept and saturates at the last register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && cmd_valid && cmd_op == OP_DUMP) begin
      cnt_q <= '0;
    end else if (state_q == ST_RESP && rsp_ready && dump_more) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end
`else
  assign is_dump   = 1'b0;
  assign dump_more = 1'b0;
  assign reg_addr  = addr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = cmd_err ? ST_RESP : ST_HALT;
      ST_HALT:   if (halt_ack) state_d = (op_q == OP_WRITE) ? ST_DATA : ST_ACCESS;
      ST_DATA:   if (cmd_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = dump_more ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          addr_q <= cmd_data[4:0];
          err_q  <= cmd_err;
          if (cmd_err) rsp_q <= RSP_ERR;
        end
        ST_DATA: if (cmd_valid) wdata_q <= cmd_data;
        ST_ACCESS: rsp_q <= (op_q == OP_WRITE) ? RSP_ACK : reg_rdata;
        default: ;
      endcase
    end
  end

  // Everything below decodes registered state only; rst gates cmd_ready so the
  // link never sees a handshake while the engine is held in reset.
  assign cmd_ready = !rst && (state_q == ST_IDLE || state_q == ST_DATA);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_q;
  assign halt_req  = (state_q != ST_IDLE) && !err_q;
  assign reg_we    = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
  assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_avr_dbg_regport.sv
// Scoreboard bench for avr_dbg_regport with a behavioural register-file model.
module tb_avr_dbg_regport;
  import avr_dbg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       halt_req;
  logic       halt_ack = 1'b0;
  logic [4:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic [7:0] reg_wdata;

  avr_dbg_regport dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .reg_we(reg_we), .reg_wdata(reg_wdata)
  );

  always #5 clk = ~clk;

  // Environment register file seen by the DUT
  logic       preload = 1'b1;
  logic [7:0] rf [32];
  assign reg_rdata = rf[reg_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 5) ? 8'h3C : (8'(i) ^ 8'h55);
    end else if (reg_we) begin
      rf[reg_addr] <= reg_wdata;
    end
  end

  // Reference model: register contents as the debug link should see them
  logic [7:0] mdl [32];
  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic rand_ready = 1'b0, ready_force = 1'b1;
  logic rand_halt  = 1'b0, halt_force  = 1'b1;

  always @(posedge clk) begin
    #1;
    rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    halt_ack  = rand_halt  ? ($urandom_range(0, 2) != 0) : halt_force;
  end

  // Monitor: pops and compares every response handshake, checks stall stability
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && rsp_valid && prev_stall) begin
      tests++;
      if (rsp_data !== prev_dat) begin
        fails++;
        $display("FAIL rsp_hold: got %02h required %02h", rsp_data, prev_dat);
      end
    end
    if (!rst && rsp_valid && rsp_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got %02h with nothing expected", rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          fails++;
          $display("FAIL rsp_data: got %02h required %02h", rsp_data, e);
        end
      end
      pops++;
    end
    prev_stall = !rst && rsp_valid && !rsp_ready;
    prev_dat   = rsp_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Presents one byte from just after a posedge; returns just after the accepting edge
  task automatic send_cmd(input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    cmd_data  = b;
    cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 500);
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Issues a command and records what the link should get back
  task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [7:0] d);
    send_cmd({op, a});
    if (op == OP_READ) begin
      exp_q.push_back(mdl[a]);
    end else if (op == OP_WRITE) begin
      send_cmd(d);
      mdl[a] = d;
      exp_q.push_back(RSP_ACK);
`ifdef AVR_DBG_DUMP_EN
    end else if (op == OP_DUMP) begin
      for (int i = 0; i < 32; i++) exp_q.push_back(mdl[i]);
`endif
    end else begin
      exp_q.push_back(RSP_ERR);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int we_cnt;
    int base;
    int n;
    for (int i = 0; i < 32; i++) mdl[i] = (i == 5) ? 8'h3C : (8'(i) ^ 8'h55);

    // Reset values
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_halt_req", 32'(halt_req), 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_reg_wdata", 32'(reg_wdata), 0);
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // READ r5 with halt_ack high: rsp at accept+3, halt_req until handshake
    issue(OP_READ, 5'd5, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("read_halt_req_%0d", k), 32'(halt_req), 1);
      chk($sformatf("read_rsp_valid_%0d", k), 32'(rsp_valid), (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("read_halt_drop", 32'(halt_req), 0);
    wait_drain("read_drain");

    // WRITE r10 = 99 then READ r10
    issue(OP_WRITE, 5'd10, 8'h99);
    we_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (reg_we) begin
        we_cnt++;
        chk("write_addr", 32'(reg_addr), 32'd10);
        chk("write_data", 32'(reg_wdata), 32'h99);
      end
    end
    chk("write_we_cycles", we_cnt, 1);
    issue(OP_READ, 5'd10, 8'h00);
    wait_drain("write_drain");

    // ERROR: response one cycle after accept, never halts
    issue(3'b111, 5'd0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("err_halt_req_%0d", k), 32'(halt_req), 0);
      if (k == 1) chk("err_rsp_valid", 32'(rsp_valid), 1);
    end
    wait_drain("err_drain");

    // halt_ack held low: nothing happens until it rises
    halt_force = 1'b0;
    @(negedge clk);
    issue(OP_READ, 5'd3, 8'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("noack_reg_we", 32'(reg_we), 0);
      chk("noack_rsp_valid", 32'(rsp_valid), 0);
    end
    halt_force = 1'b1;
    wait_drain("noack_drain");

    // DUMP with random rsp_ready stalls
    rand_ready = 1'b1;
    base = pops;
    issue(OP_DUMP, 5'd0, 8'h00);
    wait_drain("dump_drain");
`ifdef AVR_DBG_DUMP_EN
    chk("dump_count", pops - base, 32);
`else
    chk("dump_count", pops - base, 1);
`endif

    // Random traffic with random backpressure and halt_ack jitter
    rand_halt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [2:0] op;
      logic [2:0] bad_ops [5];
      bad_ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = OP_READ;
      else if (r < 7) op = OP_WRITE;
      else if (r < 8) op = OP_DUMP;
      else            op = bad_ops[$urandom_range(0, 4)];
      issue(op, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
    wait_drain("random_drain");

    // Reset while a response is stalled in RESP
    rand_halt  = 1'b0;
    rand_ready = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    base = pops;
`ifdef AVR_DBG_DUMP_EN
    issue(OP_DUMP, 5'd0, 8'h00);
    n = 0;
    while (pops < base + 3 && n < 200) begin @(negedge clk); #1; n++; end
`else
    issue(OP_READ, 5'd7, 8'h00);
`endif
    ready_force = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rsp_valid && !rsp_ready) && n < 200);
    chk("stall_reached", 32'(rsp_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_halt_req", 32'(halt_req), 0);
    chk("midrst_reg_we", 32'(reg_we), 0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 0);
    exp_q.delete();
    rst = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    chk("postrst_cmd_ready", 32'(cmd_ready), 1);
    issue(OP_READ, 5'd5, 8'h00);
    wait_drain("postrst_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
